// File: rtl/ysyx_24110026_core_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the NPC core with memory-wait timeout and sticky halt.
// Optional cycle/instret performance counters are built when CORE_CTRL_PERF_EN is defined.
module ysyx_24110026_core_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
`ifdef CORE_CTRL_PERF_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req,
    input  logic              ifu_valid,
    input  logic [31:0]       inst_in,
    output logic [31:0]       inst_out,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic              dec_is_ebreak,
    input  logic              dec_illegal,
    input  logic              dec_rd_wen,
    output logic              lsu_req,
    output logic              lsu_we,
    input  logic              lsu_done,
    output logic              rf_wen,
    output logic              pc_wen,
    output logic              halt,
    output logic [1:0]        halt_code,
`ifdef CORE_CTRL_PERF_EN
    output logic [PERF_W-1:0] perf_cycle,
    output logic [PERF_W-1:0] perf_instret,
`endif
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [1:0] CODE_EBREAK  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [31:0]      inst_q;
    logic             load_q, store_q, rd_wen_q;
    logic             ifu_req_q, lsu_req_q, lsu_we_q, rf_wen_q, pc_wen_q, halt_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                if (ifu_valid) begin
                    state_d = S_ID;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    code_d  = CODE_TIMEOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ID: begin
                if (dec_illegal) begin
                    state_d = S_HALT;
                    code_d  = CODE_ILLEGAL;
                end else if (dec_is_ebreak) begin
                    state_d = S_HALT;
                    code_d  = CODE_EBREAK;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                // A decode claiming both load and store is malformed.
                if (load_q && store_q) begin
                    state_d = S_HALT;
                    code_d  = CODE_ILLEGAL;
                end else if (load_q || store_q) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_d = S_WB;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    code_d  = CODE_TIMEOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q and never glitch.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            inst_q    <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            rd_wen_q  <= 1'b0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_we_q  <= 1'b0;
            rf_wen_q  <= 1'b0;
            pc_wen_q  <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            if (state_q == S_IF && ifu_valid) begin
                inst_q <= inst_in;
            end
            if (state_q == S_ID) begin
                load_q   <= dec_is_load;
                store_q  <= dec_is_store;
                rd_wen_q <= dec_rd_wen;
            end
            ifu_req_q <= (state_d == S_IF);
            lsu_req_q <= (state_d == S_MEM);
            lsu_we_q  <= (state_d == S_MEM) && store_q;
            rf_wen_q  <= (state_d == S_WB) && rd_wen_q;
            pc_wen_q  <= (state_d == S_WB);
            halt_q    <= (state_d == S_HALT);
        end
    end

    assign ifu_req   = ifu_req_q;
    assign lsu_req   = lsu_req_q;
    assign lsu_we    = lsu_we_q;
    assign rf_wen    = rf_wen_q;
    assign pc_wen    = pc_wen_q;
    assign halt      = halt_q;
    assign halt_code = code_q;
    assign inst_out  = inst_q;
    assign state_dbg = state_q;

`ifdef CORE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_cycle_q, perf_instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) begin
                perf_cycle_q <= perf_cycle_q + PERF_W'(1);
            end
            if (pc_wen_q) begin
                perf_instret_q <= perf_instret_q + PERF_W'(1);
            end
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule
